sound_ac97_frame_tx: RTL and testbench

SOUND_AC97_FRAME_TX -- requirements
Module: sound_ac97_frame_tx

---
 rtl/sound_ac97_frame_tx_pkg.sv | 66 ++++++
 rtl/sound_ac97_frame_tx_if.sv | 11 +
 rtl/sound_ac97_frame_tx_slot_shifter.sv | 36 +++
 rtl/sound_ac97_frame_tx.sv | 105 ++++++++++
 tb/tb_sound_ac97_frame_tx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/sound_ac97_frame_tx_pkg.sv
// Shared sound constants plus AC'97 frame geometry and the frame-image builder.
package sound_ac97_frame_tx_pkg;

  localparam int unsigned SAMPLE_W   = 20;
  localparam int unsigned CMD_ADDR_W = 7;
  localparam int unsigned CMD_DATA_W = 16;

  localparam int unsigned FRAME_LEN = 256;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned TAG_W     = 16;
  localparam int unsigned SLOT_W    = 20;
  localparam int unsigned NUM_SLOTS = 12;
  localparam int unsigned SYNC_LEN  = 16;

  localparam int unsigned TAG_READY_BIT    = 15;
  localparam int unsigned TAG_CMD_ADDR_BIT = 14;
  localparam int unsigned TAG_CMD_DATA_BIT = 13;
  localparam int unsigned TAG_PCM_L_BIT    = 12;
  localparam int unsigned TAG_PCM_R_BIT    = 11;

  localparam int unsigned SLOT_CMD_ADDR = 1;
  localparam int unsigned SLOT_CMD_DATA = 2;
  localparam int unsigned SLOT_PCM_L    = 3;
  localparam int unsigned SLOT_PCM_R    = 4;

  // Image bit FRAME_LEN-1 is frame bit 0, so slot s starts at this image index.
  localparam int unsigned SLOT_CMD_ADDR_MSB = FRAME_LEN - 1 - TAG_W - (SLOT_CMD_ADDR - 1) * SLOT_W;
  localparam int unsigned SLOT_CMD_DATA_MSB = FRAME_LEN - 1 - TAG_W - (SLOT_CMD_DATA - 1) * SLOT_W;
  localparam int unsigned SLOT_PCM_L_MSB    = FRAME_LEN - 1 - TAG_W - (SLOT_PCM_L - 1) * SLOT_W;
  localparam int unsigned SLOT_PCM_R_MSB    = FRAME_LEN - 1 - TAG_W - (SLOT_PCM_R - 1) * SLOT_W;

  typedef logic [FRAME_LEN-1:0] frame_t;

  typedef struct packed {
    logic                  rw;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } ac97_cmd_t;

  function automatic frame_t build_frame(input logic          cmd_present,
                                         input ac97_cmd_t     cmd,
                                         input logic          pcm_valid,
                                         input logic [SAMPLE_W-1:0] left,
                                         input logic [SAMPLE_W-1:0] right);
    frame_t           img;
    logic [TAG_W-1:0] tag;
    img = '0;
    tag = '0;
    tag[TAG_READY_BIT]    = 1'b1;
    tag[TAG_CMD_ADDR_BIT] = cmd_present;
    tag[TAG_CMD_DATA_BIT] = cmd_present;
    tag[TAG_PCM_L_BIT]    = pcm_valid;
    tag[TAG_PCM_R_BIT]    = pcm_valid;
    img[FRAME_LEN-1 -: TAG_W] = tag;
    if (cmd_present) begin
      img[SLOT_CMD_ADDR_MSB -: SLOT_W] = {cmd.rw, cmd.addr, 12'h000};
      img[SLOT_CMD_DATA_MSB -: SLOT_W] = cmd.rw ? SLOT_W'(0) : {cmd.data, 4'h0};
    end
    if (pcm_valid) begin
      img[SLOT_PCM_L_MSB -: SLOT_W] = left;
      img[SLOT_PCM_R_MSB -: SLOT_W] = right;
    end
    return img;
  endfunction

endpackage

// File: rtl/sound_ac97_frame_tx_if.sv
// Parallel-load path between the frame builder and the slot shifter.
interface sound_ac97_frame_tx_if;
  import sound_ac97_frame_tx_pkg::*;

  logic   load;
  frame_t image;
  logic   sdata;

  modport master (output load, output image, input sdata);
  modport slave  (input load, input image, output sdata);
endinterface

// File: rtl/sound_ac97_frame_tx_slot_shifter.sv
// 256-bit parallel-load shift register; emits image MSB first, one bit per clock.
module ac97_slot_shifter
  import sound_ac97_frame_tx_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  sound_ac97_frame_tx_if.slave shf_if
);
  frame_t shreg_q, shreg_d;
  logic   sdata_q, sdata_d;

  // On load the first bit goes straight to the output register so bit 0 appears with the latch.
  always_comb begin
    shreg_d = shreg_q;
    sdata_d = sdata_q;
    if (shf_if.load) begin
      sdata_d = shf_if.image[FRAME_LEN-1];
      shreg_d = {shf_if.image[FRAME_LEN-2:0], 1'b0};
    end else begin
      sdata_d = shreg_q[FRAME_LEN-1];
      shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      sdata_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      sdata_q <= sdata_d;
    end
  end

  assign shf_if.sdata = sdata_q;
endmodule

// File: rtl/sound_ac97_frame_tx.sv
// AC'97 SDATA_OUT/SYNC frame transmitter: latches a tag+slot image at each frame wrap.
// Codec command path is present only when SOUND_AC97_CMD_EN is defined.
module sound_ac97_frame_tx
  import sound_ac97_frame_tx_pkg::*;
(
  input  logic                  I_CLK,
  input  logic                  I_RESET,
  input  logic [SAMPLE_W-1:0]   I_LEFT_SAMPLE,
  input  logic [SAMPLE_W-1:0]   I_RIGHT_SAMPLE,
  input  logic                  I_SAMPLE_VALID,
  output logic                  O_FRAME_START,
  input  logic                  I_CMD_VALID,
  input  logic                  I_CMD_RW,
  input  logic [CMD_ADDR_W-1:0] I_CMD_ADDR,
  input  logic [CMD_DATA_W-1:0] I_CMD_DATA,
  output logic                  O_CMD_READY,
  output logic                  O_SYNC,
  output logic                  O_SDATA
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_q, sync_d;
  logic             fstart_q, fstart_d;
  logic             latch_c;
  logic             cmd_present_c;
  ac97_cmd_t        cmd_c;
  frame_t           frame_c;

  sound_ac97_frame_tx_if u_shf_if ();

  assign latch_c = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    sync_d   = (cnt_d < CNT_W'(SYNC_LEN));
    fstart_d = latch_c;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cnt_q    <= CNT_W'(FRAME_LEN - 1);
      sync_q   <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      fstart_q <= fstart_d;
    end
  end

`ifdef SOUND_AC97_CMD_EN
  ac97_cmd_t cmd_q, cmd_d;
  logic      cmd_empty_q, cmd_empty_d;

  // Frame uses the pre-edge holding register, so a command taken on the latch edge waits a frame.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_empty_d = cmd_empty_q;
    if (latch_c) begin
      cmd_empty_d = 1'b1;
    end
    if (I_CMD_VALID && cmd_empty_q) begin
      cmd_d.rw    = I_CMD_RW;
      cmd_d.addr  = I_CMD_ADDR;
      cmd_d.data  = I_CMD_DATA;
      cmd_empty_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      cmd_q       <= '0;
      cmd_empty_q <= 1'b1;
    end else begin
      cmd_q       <= cmd_d;
      cmd_empty_q <= cmd_empty_d;
    end
  end

  assign cmd_c         = cmd_q;
  assign cmd_present_c = ~cmd_empty_q;
  assign O_CMD_READY   = cmd_empty_q;
`else
  logic unused_cmd;
  assign unused_cmd    = ^{I_CMD_VALID, I_CMD_RW, I_CMD_ADDR, I_CMD_DATA};
  assign cmd_c         = '0;
  assign cmd_present_c = 1'b0;
  assign O_CMD_READY   = 1'b0;
`endif

  assign frame_c = build_frame(cmd_present_c, cmd_c, I_SAMPLE_VALID,
                               I_LEFT_SAMPLE, I_RIGHT_SAMPLE);

  assign u_shf_if.load  = latch_c;
  assign u_shf_if.image = frame_c;

  ac97_slot_shifter u_shifter (
    .clk_i  (I_CLK),
    .rst_i  (I_RESET),
    .shf_if (u_shf_if)
  );

  assign O_SYNC        = sync_q;
  assign O_FRAME_START = fstart_q;
  assign O_SDATA       = u_shf_if.sdata;
endmodule

// File: tb/tb_sound_ac97_frame_tx.sv
// Scoreboard bench for sound_ac97_frame_tx: reference frames queued at each latch, serial capture compared per frame.
module tb_sound_ac97_frame_tx;
  import sound_ac97_frame_tx_pkg::*;

`ifdef SOUND_AC97_CMD_EN
  localparam bit CMD_EN = 1'b1;
`else
  localparam bit CMD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] left = '0, right = '0;
  logic        valid = 1'b0;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        frame_start, cmd_ready, sync_o, sdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sound_ac97_frame_tx dut (
    .I_CLK          (clk),
    .I_RESET        (rst),
    .I_LEFT_SAMPLE  (left),
    .I_RIGHT_SAMPLE (right),
    .I_SAMPLE_VALID (valid),
    .O_FRAME_START  (frame_start),
    .I_CMD_VALID    (cmd_valid),
    .I_CMD_RW       (cmd_rw),
    .I_CMD_ADDR     (cmd_addr),
    .I_CMD_DATA     (cmd_data),
    .O_CMD_READY    (cmd_ready),
    .O_SYNC         (sync_o),
    .O_SDATA        (sdata_o)
  );

  sound_ac97_frame_tx_if mon_if ();
  assign mon_if.sdata = sdata_o;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference frame: tag then twelve 20-bit slots, serialised into a bit list.
  function automatic logic [255:0] ref_frame(input bit cmd_on, input bit rw, input bit [6:0] addr,
                                             input bit [15:0] data, input bit v,
                                             input bit [19:0] l, input bit [19:0] r);
    bit [19:0]     slots [1:12];
    bit [15:0]     tag;
    bit            q[$];
    logic [255:0]  f;
    tag = 16'h8000;
    if (cmd_on) tag = tag | 16'h6000;
    if (v) tag = tag | 16'h1800;
    for (int s = 1; s <= 12; s++) slots[s] = '0;
    if (cmd_on) begin
      slots[1] = {rw, addr, 12'h000};
      slots[2] = rw ? 20'h0 : {data, 4'h0};
    end
    if (v) begin
      slots[3] = l;
      slots[4] = r;
    end
    for (int b = 15; b >= 0; b--) q.push_back(tag[b]);
    for (int s = 1; s <= 12; s++)
      for (int b = 19; b >= 0; b--) q.push_back(slots[s][b]);
    for (int i = 0; i < 256; i++) f[255-i] = q[i];
    return f;
  endfunction

  // Model: frame position after each edge, command holding state, expected frame queue.
  int           m_pos = 255;
  bit           m_empty = 1'b1;
  bit           m_in_reset = 1'b1;
  bit           m_started = 1'b0;
  bit           m_acc;
  bit           m_rw;
  bit [6:0]     m_addr;
  bit [15:0]    m_data;
  logic [255:0] exp_q[$];
  int           frames_pushed = 0, frames_dropped = 0, frames_seen = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 255;
      m_empty = 1'b1;
      m_in_reset = 1'b1;
      frames_dropped += exp_q.size();
      exp_q.delete();
    end else begin
      m_acc = CMD_EN && cmd_valid && m_empty;
      if (m_pos == 255) begin
        exp_q.push_back(ref_frame(!m_empty, m_rw, m_addr, m_data, valid, left, right));
        frames_pushed++;
        m_empty = 1'b1;
      end
      if (m_acc) begin
        m_rw = cmd_rw;
        m_addr = cmd_addr;
        m_data = cmd_data;
        m_empty = 1'b0;
      end
      m_pos = (m_pos + 1) % 256;
      m_in_reset = 1'b0;
    end
    m_started = 1'b1;
  end

  // Monitor: per-cycle SYNC/FRAME_START/READY checks and serial frame capture.
  int           cap_idx = 0;
  bit           capturing = 1'b0;
  logic [255:0] exp_f;

  always @(negedge clk) begin
    mon_if.load = 1'b0;
    if (m_started) begin
      chk("sync", sync_o, !m_in_reset && m_pos < 16);
      chk("frame_start", frame_start, !m_in_reset && m_pos == 0);
      chk("cmd_ready", cmd_ready, CMD_EN && m_empty);
      if (m_in_reset) chk("sdata_in_reset", sdata_o, 1'b0);
    end
    if (rst) begin
      capturing = 1'b0;
    end else begin
      if (frame_start) begin
        capturing = 1'b1;
        cap_idx = 0;
      end
      if (capturing) begin
        mon_if.image[255-cap_idx] = mon_if.sdata;
        cap_idx++;
        if (cap_idx == 256) begin
          capturing = 1'b0;
          mon_if.load = 1'b1;
        end
      end
    end
    if (mon_if.load) begin
      frames_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected @%0t: got frame %h, expected none", $time, mon_if.image);
      end else begin
        exp_f = exp_q.pop_front();
        chk("frame", mon_if.image, exp_f);
      end
    end
  end

  task automatic wait_pos(input int k);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (m_pos == k && !m_in_reset) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: got timeout, expected frame bit %0d", k);
    end
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      left      = 20'($urandom);
      right     = 20'($urandom);
      valid     = 1'($urandom_range(0, 1));
      cmd_valid = ($urandom_range(0, 7) == 0);
      cmd_rw    = 1'($urandom_range(0, 1));
      cmd_addr  = 7'($urandom);
      cmd_data  = 16'($urandom);
    end
  endtask

  initial begin
    left  = 20'h12345;
    right = 20'hABCDE;
    valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    // frame 0 carries 12345/ABCDE; frame 1 has valid low
    wait_pos(100);
    valid = 1'b0;
    // write command mid-frame 1, goes out in frame 2
    wait_pos(100);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_addr  = 7'h02;
    cmd_data  = 16'h0808;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    // read command offered on the latch edge ending frame 2: absent from 3, present in 4
    wait_pos(0);
    wait_pos(255);
    cmd_valid = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 7'h26;
    cmd_data  = 16'hFFFF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_pos(0);
    wait_pos(0);
    rand_cycles(20 * 256);
    // reset in the middle of a frame
    wait_pos(100);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rand_cycles(4 * 256 + 37);
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    chk("frame_count", 256'(frames_seen), 256'(frames_pushed - frames_dropped - exp_q.size()));
    chk("frames_in_flight", 256'(exp_q.size() <= 1), 256'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
